// File: rtl/vga_mem_arbiter_if.sv
// Host and frame-memory bus bundle for the video memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              host_req_i;
    logic              host_we_i;
    logic [ADDR_W-1:0] host_addr_i;
    logic [DATA_W-1:0] host_wdata_i;
    logic              host_ack_o;
    logic              host_rvalid_o;
    logic [DATA_W-1:0] host_rdata_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              fetch_valid_o;
    logic [5:0]        fetch_idx_o;
    logic [DATA_W-1:0] fetch_data_o;
    logic              fetch_done_o;

    modport slave (
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i, mem_rdata_i,
        output host_ack_o, host_rvalid_o, host_rdata_o,
        output mem_addr_o, mem_we_o, mem_wdata_o,
        output fetch_valid_o, fetch_idx_o, fetch_data_o, fetch_done_o
    );

    modport master (
        output host_req_i, host_we_i, host_addr_i, host_wdata_i, mem_rdata_i,
        input  host_ack_o, host_rvalid_o, host_rdata_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o,
        input  fetch_valid_o, fetch_idx_o, fetch_data_o, fetch_done_o
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port frame memory arbiter: video line prefetch during hblank has
// priority, every other memory cycle is handed to the host port.
module vga_mem_arbiter #(
    parameter int LINE_WORDS = 40,
    parameter int V_DISPLAY  = 480,
    parameter int V_TOTAL    = 524,
    parameter int FETCH_HPOS = 640,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [9:0] hpos_i,
    input  logic [8:0] vpos_i,
    input  logic       fetch_en_i,
    output logic       overrun_o,
    vga_mem_arbiter_if.slave bus
);
    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    // read-return tags: which requester owns the word coming back next cycle
    logic              rd_host_q, rd_host_d;
    logic              rd_fetch_q, rd_fetch_d;
    logic              rd_last_q, rd_last_d;
    logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;

    logic [8:0] next_line;
    logic       trigger;
    logic       go;
    logic       host_go;
    logic       last_word;

    assign next_line = (vpos_i == 9'(V_TOTAL - 1)) ? 9'd0 : vpos_i + 9'd1;
    assign trigger   = (hpos_i == 10'(FETCH_HPOS)) && fetch_en_i &&
                       (next_line < 9'(V_DISPLAY));
    assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));
    assign go        = (state_q == S_IDLE) && (pending_q || trigger);
    // fetch wins over a simultaneous host request; the host just waits
    assign host_go   = rst_ni && (state_q == S_IDLE) && !go && bus.host_req_i;

    // next-state: FSM, word counter, base latch, overrun flag, read tags
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        rd_host_d  = host_go && !bus.host_we_i;
        rd_fetch_d = (state_q == S_FETCH);
        rd_last_d  = (state_q == S_FETCH) && last_word;
        rd_idx_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) pending_d = 1'b1;
                if (go) begin
                    state_d   = S_FETCH;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    base_d    = ADDR_W'(next_line) * ADDR_W'(LINE_WORDS);
                end
            end
            default: begin
                // a second trigger mid-line cannot be honoured; flag it
                if (trigger) overrun_d = 1'b1;
                if (last_word) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // state registers, synchronous active-low reset drops any in-flight read
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            rd_host_q  <= 1'b0;
            rd_fetch_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            rd_host_q  <= rd_host_d;
            rd_fetch_q <= rd_fetch_d;
            rd_last_q  <= rd_last_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    // memory command mux: fetch read, host access, or a quiet bus
    always_comb begin
        bus.mem_addr_o  = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_wdata_o = '0;
        if (state_q == S_FETCH) begin
            bus.mem_addr_o = base_q + ADDR_W'(cnt_q);
        end else if (host_go) begin
            bus.mem_addr_o  = bus.host_addr_i;
            bus.mem_we_o    = bus.host_we_i;
            bus.mem_wdata_o = bus.host_wdata_i;
        end
    end

    assign bus.host_ack_o    = host_go;
    assign bus.host_rvalid_o = rd_host_q;
    assign bus.host_rdata_o  = rd_host_q ? bus.mem_rdata_i : '0;
    assign bus.fetch_valid_o = rd_fetch_q;
    assign bus.fetch_idx_o   = 6'(rd_idx_q);
    assign bus.fetch_data_o  = rd_fetch_q ? bus.mem_rdata_i : '0;
    assign bus.fetch_done_o  = rd_fetch_q && rd_last_q;
    assign overrun_o         = overrun_q;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: one 40-word instance for the main
// cases and a 200-word instance to provoke an overrun.
module tb_vga_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [9:0] hpos, hpos2;
    logic [8:0] vpos, vpos2;
    logic       fen;
    logic       ovr0, ovr1;

    int n_vec = 0;
    int n_bad = 0;

    vga_mem_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus0 ();
    vga_mem_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus1 ();

    vga_mem_arbiter #(.LINE_WORDS(40)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .hpos_i(hpos), .vpos_i(vpos),
        .fetch_en_i(fen), .overrun_o(ovr0), .bus(bus0)
    );

    vga_mem_arbiter #(.LINE_WORDS(200)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .hpos_i(hpos2), .vpos_i(vpos2),
        .fetch_en_i(fen), .overrun_o(ovr1), .bus(bus1)
    );

    // frame memory contents: address pattern, 0xBEEF planted at word 5
    function automatic logic [15:0] pat(input logic [14:0] a);
        if (a == 15'd5) return 16'hBEEF;
        return {1'b0, a} ^ 16'hC35A;
    endfunction

    // memory for dut0: pattern plus one writable word, 1-cycle read latency
    logic        wv = 1'b0;
    logic [14:0] wa = '0;
    logic [15:0] wd = '0;
    always @(posedge clk) begin
        if (bus0.mem_we_o) begin
            wv <= 1'b1;
            wa <= bus0.mem_addr_o;
            wd <= bus0.mem_wdata_o;
        end
        bus0.mem_rdata_i <= (wv && wa == bus0.mem_addr_o) ? wd : pat(bus0.mem_addr_o);
    end

    // memory for dut1: read-only pattern
    always @(posedge clk) bus1.mem_rdata_i <= pat(bus1.mem_addr_o);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // trigger at hpos 640 for line v, then check every issued address and returned word
    task automatic run_line(input logic [8:0] v, input logic [14:0] base);
        vpos = v;
        hpos = 10'd640;
        #1;
        chk("trig_we", bus0.mem_we_o, 0);
        for (int j = 1; j <= 42; j++) begin
            cyc();
            hpos = hpos + 10'd1;
            #1;
            if (j <= 40) begin
                chk("f_addr", bus0.mem_addr_o, base + j - 1);
                chk("f_we", bus0.mem_we_o, 0);
            end
            if (j >= 2 && j <= 41) begin
                chk("f_valid", bus0.fetch_valid_o, 1);
                chk("f_idx", bus0.fetch_idx_o, j - 2);
                chk("f_data", bus0.fetch_data_o, pat(base + 15'(j - 2)));
                chk("f_done", bus0.fetch_done_o, (j == 41) ? 1 : 0);
            end
            if (j == 42) chk("f_end", bus0.fetch_valid_o, 0);
        end
        hpos = 10'd0;
    endtask

    initial begin
        int acks, dn, nv;
        rst_n = 1'b0; hpos = '0; hpos2 = '0; vpos = '0; vpos2 = '0; fen = 1'b1;
        bus0.host_req_i = 1'b0; bus0.host_we_i = 1'b0; bus0.host_addr_i = '0; bus0.host_wdata_i = '0;
        bus1.host_req_i = 1'b0; bus1.host_we_i = 1'b0; bus1.host_addr_i = '0; bus1.host_wdata_i = '0;
        repeat (2) cyc();
        #1;
        chk("rst_ack", bus0.host_ack_o, 0);
        chk("rst_rvalid", bus0.host_rvalid_o, 0);
        chk("rst_addr", bus0.mem_addr_o, 0);
        chk("rst_we", bus0.mem_we_o, 0);
        chk("rst_fvalid", bus0.fetch_valid_o, 0);
        chk("rst_done", bus0.fetch_done_o, 0);
        chk("rst_ovr", ovr0, 0);
        rst_n = 1'b1;
        cyc();

        // line 1 prefetch, then the wrap case: vpos 523 fetches line 0
        run_line(9'd0, 15'd40);
        chk("ovr_after_line", ovr0, 0);
        cyc();
        run_line(9'd523, 15'd0);

        // no trigger when the next line is in vertical blanking
        for (int i = 0; i < 2; i++) begin
            cyc();
            vpos = (i == 0) ? 9'd479 : 9'd500;
            hpos = 10'd640;
            #1;
            chk("vb_we", bus0.mem_we_o, 0);
            cyc();
            hpos = 10'd641;
            #1;
            chk("vb_addr", bus0.mem_addr_o, 0);
            cyc();
            #1;
            chk("vb_fvalid", bus0.fetch_valid_o, 0);
            hpos = 10'd0;
        end

        // host write held from the trigger cycle waits out the whole fetch
        cyc();
        vpos = 9'd1; hpos = 10'd640;
        bus0.host_req_i = 1'b1; bus0.host_we_i = 1'b1;
        bus0.host_addr_i = 15'h0100; bus0.host_wdata_i = 16'h1234;
        #1;
        acks = int'(bus0.host_ack_o);
        for (int j = 1; j <= 40; j++) begin
            cyc();
            hpos = hpos + 10'd1;
            #1;
            acks += int'(bus0.host_ack_o);
        end
        chk("blocked_acks", acks, 0);
        cyc();
        #1;
        chk("wr_ack", bus0.host_ack_o, 1);
        chk("wr_we", bus0.mem_we_o, 1);
        chk("wr_addr", bus0.mem_addr_o, 32'h0100);
        chk("wr_data", bus0.mem_wdata_o, 32'h1234);
        cyc();
        bus0.host_we_i = 1'b0;
        #1;
        chk("rb_ack", bus0.host_ack_o, 1);
        chk("rb_we", bus0.mem_we_o, 0);
        cyc();
        bus0.host_req_i = 1'b0;
        #1;
        chk("rb_rvalid", bus0.host_rvalid_o, 1);
        chk("rb_rdata", bus0.host_rdata_o, 32'h1234);
        hpos = 10'd0;

        // host read acked the cycle before the trigger returns alongside the fetch start
        cyc();
        vpos = 9'd2; hpos = 10'd639;
        bus0.host_req_i = 1'b1; bus0.host_we_i = 1'b0; bus0.host_addr_i = 15'd5;
        #1;
        chk("pre_ack", bus0.host_ack_o, 1);
        chk("pre_addr", bus0.mem_addr_o, 5);
        cyc();
        hpos = 10'd640; bus0.host_req_i = 1'b0;
        #1;
        chk("pre_rvalid", bus0.host_rvalid_o, 1);
        chk("pre_rdata", bus0.host_rdata_o, 32'hBEEF);
        chk("pre_fvalid", bus0.fetch_valid_o, 0);
        cyc();
        hpos = 10'd641;
        #1;
        chk("pre_faddr", bus0.mem_addr_o, 120);
        chk("pre_rv_gone", bus0.host_rvalid_o, 0);
        chk("pre_fv_wait", bus0.fetch_valid_o, 0);
        cyc();
        hpos = 10'd642;
        #1;
        chk("pre_fv0", bus0.fetch_valid_o, 1);
        chk("pre_fidx0", bus0.fetch_idx_o, 0);
        chk("pre_fdata0", bus0.fetch_data_o, pat(15'd120));
        dn = 0;
        for (int j = 0; j < 50; j++) begin
            cyc();
            hpos = hpos + 10'd1;
            #1;
            dn += int'(bus0.fetch_done_o);
        end
        chk("pre_done_cnt", dn, 1);
        hpos = 10'd0;

        // 200-word line with a second trigger mid-fetch
        cyc();
        hpos2 = 10'd640;
        #1;
        cyc();
        hpos2 = 10'd641;
        #1;
        chk("ov_base", bus1.mem_addr_o, 200);
        nv = 0; dn = 0;
        for (int j = 2; j <= 260; j++) begin
            if (j == 49) chk("ov_before", ovr1, 0);
            cyc();
            hpos2 = (j == 50) ? 10'd640 : hpos2 + 10'd1;
            #1;
            nv += int'(bus1.fetch_valid_o);
            dn += int'(bus1.fetch_done_o);
        end
        chk("ov_words", nv, 200);
        chk("ov_done", dn, 1);
        chk("ov_sticky", ovr1, 1);
        chk("ov_other", ovr0, 0);
        hpos2 = 10'd0;

        // reset while word 10 is being issued aborts the line
        cyc();
        vpos = 9'd3; hpos = 10'd640;
        #1;
        for (int j = 1; j <= 11; j++) begin
            cyc();
            hpos = hpos + 10'd1;
            #1;
        end
        chk("ab_addr10", bus0.mem_addr_o, 170);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("ab_fvalid", bus0.fetch_valid_o, 0);
        chk("ab_fidx", bus0.fetch_idx_o, 0);
        chk("ab_fdata", bus0.fetch_data_o, 0);
        chk("ab_done", bus0.fetch_done_o, 0);
        chk("ab_addr", bus0.mem_addr_o, 0);
        chk("ab_we", bus0.mem_we_o, 0);
        chk("ab_ack", bus0.host_ack_o, 0);
        chk("ab_rvalid", bus0.host_rvalid_o, 0);
        chk("ab_ovr", ovr0, 0);
        cyc();
        bus0.host_req_i = 1'b1; bus0.host_we_i = 1'b0; bus0.host_addr_i = 15'd7;
        #1;
        chk("ab_hack", bus0.host_ack_o, 1);
        chk("ab_haddr", bus0.mem_addr_o, 7);
        cyc();
        bus0.host_req_i = 1'b0;
        #1;
        chk("ab_hrvalid", bus0.host_rvalid_o, 1);
        chk("ab_hrdata", bus0.host_rdata_o, pat(15'd7));
        dn = 0; nv = 0;
        for (int j = 0; j < 45; j++) begin
            cyc();
            hpos = hpos + 10'd1;
            #1;
            dn += int'(bus0.fetch_done_o);
            nv += int'(bus0.fetch_valid_o);
        end
        chk("ab_no_done", dn, 0);
        chk("ab_no_valid", nv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
